// File: rtl/control_unit_pkg.sv
// Shared definitions for the Mini-SRC hardwired control unit: opcodes,
// MDR mux selects, sequencer states, the control-strobe bundle and the
// per-opcode execute decode.
package control_unit_pkg;

  typedef enum logic [4:0] {
    OP_LD   = 5'b00000, OP_LDI  = 5'b00001, OP_ST   = 5'b00010, OP_ADD  = 5'b00011,
    OP_SUB  = 5'b00100, OP_AND  = 5'b00101, OP_OR   = 5'b00110, OP_SHR  = 5'b00111,
    OP_SHRA = 5'b01000, OP_SHL  = 5'b01001, OP_ROR  = 5'b01010, OP_ROL  = 5'b01011,
    OP_ADDI = 5'b01100, OP_ANDI = 5'b01101, OP_ORI  = 5'b01110, OP_MUL  = 5'b01111,
    OP_DIV  = 5'b10000, OP_NEG  = 5'b10001, OP_NOT  = 5'b10010, OP_BR   = 5'b10011,
    OP_JR   = 5'b10100, OP_JAL  = 5'b10101, OP_IN   = 5'b10110, OP_OUT  = 5'b10111,
    OP_MFHI = 5'b11000, OP_MFLO = 5'b11001, OP_NOP  = 5'b11010, OP_HALT = 5'b11011
  } opcode_e;

  typedef enum logic [2:0] {
    MDR_SEL_NONE = 3'b000,
    MDR_SEL_BUS  = 3'b001,
    MDR_SEL_RAM  = 3'b010,
    MDR_SEL_MDIN = 3'b100
  } mdr_sel_e;

  typedef enum logic [1:0] {
    S_RESET = 2'd0,
    S_RUN   = 2'd1,
    S_HALT  = 2'd2
  } state_e;

  typedef struct packed {
    logic Gra, Grb, Grc, R_enable, Rout, BAout, Cout;
    logic PCout, MDRout, ZLowout, ZHighout, HIout, LOout, InPortout, Yout;
    logic PC_enable, IR_enable, MAR_enable, MDR_enable, Y_enable;
    logic Z_enable, HI_enable, LO_enable, CON_enable, OutPort_enable;
    logic IncPC, RAM_read, RAM_write;
    mdr_sel_e MDR_read;
  } ctrl_t;

  // Final control step of each instruction; nop, halt and undefined opcodes end after fetch.
  function automatic logic [3:0] last_step(input logic [4:0] op);
    logic [3:0] n;
    n = 4'd3;
    case (op)
      OP_LD:                                   n = 4'd9;
      OP_ST:                                   n = 4'd8;
      OP_MUL, OP_DIV, OP_BR:                   n = 4'd7;
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SHR, OP_SHRA, OP_SHL, OP_ROR, OP_ROL,
      OP_ADDI, OP_ANDI, OP_ORI, OP_LDI:        n = 4'd6;
      OP_NEG, OP_NOT, OP_JAL:                  n = 4'd5;
      OP_JR, OP_IN, OP_OUT, OP_MFHI, OP_MFLO:  n = 4'd4;
      default:                                 n = 4'd3;
    endcase
    return n;
  endfunction

  // Strobes for execute steps T4 and later.
  function automatic ctrl_t exec_ctrl(input logic [4:0] op, input logic [3:0] step, input logic con);
    ctrl_t c;
    c = '0;
    case (op)
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SHR, OP_SHRA, OP_SHL, OP_ROR, OP_ROL,
      OP_ADDI, OP_ANDI, OP_ORI: begin
        case (step)
          4'd4: begin c.Grb = 1'b1; c.Rout = 1'b1; c.Y_enable = 1'b1; end
          4'd5: begin
            if (op inside {OP_ADDI, OP_ANDI, OP_ORI}) c.Cout = 1'b1;
            else begin c.Grc = 1'b1; c.Rout = 1'b1; end
            c.Z_enable = 1'b1;
          end
          4'd6: begin c.ZLowout = 1'b1; c.Gra = 1'b1; c.R_enable = 1'b1; end
          default: ;
        endcase
      end
      OP_NEG, OP_NOT: begin
        case (step)
          4'd4: begin c.Grb = 1'b1; c.Rout = 1'b1; c.Z_enable = 1'b1; end
          4'd5: begin c.ZLowout = 1'b1; c.Gra = 1'b1; c.R_enable = 1'b1; end
          default: ;
        endcase
      end
      OP_MUL, OP_DIV: begin
        case (step)
          4'd4: begin c.Gra = 1'b1; c.Rout = 1'b1; c.Y_enable = 1'b1; end
          4'd5: begin c.Grb = 1'b1; c.Rout = 1'b1; c.Z_enable = 1'b1; end
          4'd6: begin c.ZLowout = 1'b1; c.LO_enable = 1'b1; end
          4'd7: begin c.ZHighout = 1'b1; c.HI_enable = 1'b1; end
          default: ;
        endcase
      end
      OP_LD, OP_LDI, OP_ST: begin
        case (step)
          4'd4: begin c.Grb = 1'b1; c.BAout = 1'b1; c.Rout = 1'b1; c.Y_enable = 1'b1; end
          4'd5: begin c.Cout = 1'b1; c.Z_enable = 1'b1; end
          4'd6: begin
            c.ZLowout = 1'b1;
            if (op == OP_LDI) begin c.Gra = 1'b1; c.R_enable = 1'b1; end
            else c.MAR_enable = 1'b1;
          end
          4'd7: begin
            if (op == OP_LD) c.RAM_read = 1'b1;
            else if (op == OP_ST) begin
              c.Gra = 1'b1; c.Rout = 1'b1; c.MDR_enable = 1'b1; c.MDR_read = MDR_SEL_BUS;
            end
          end
          4'd8: begin
            if (op == OP_LD) begin c.MDR_enable = 1'b1; c.MDR_read = MDR_SEL_RAM; end
            else if (op == OP_ST) c.RAM_write = 1'b1;
          end
          4'd9: if (op == OP_LD) begin c.MDRout = 1'b1; c.Gra = 1'b1; c.R_enable = 1'b1; end
          default: ;
        endcase
      end
      OP_BR: begin
        case (step)
          4'd4: begin c.Gra = 1'b1; c.Rout = 1'b1; c.CON_enable = 1'b1; end
          4'd5: begin c.PCout = 1'b1; c.Y_enable = 1'b1; end
          4'd6: begin c.Cout = 1'b1; c.Z_enable = 1'b1; end
          4'd7: if (con) begin c.ZLowout = 1'b1; c.PC_enable = 1'b1; end
          default: ;
        endcase
      end
      OP_JR:   if (step == 4'd4) begin c.Gra = 1'b1; c.Rout = 1'b1; c.PC_enable = 1'b1; end
      OP_JAL: begin
        case (step)
          4'd4: begin c.PCout = 1'b1; c.Gra = 1'b1; c.R_enable = 1'b1; end
          4'd5: begin c.Grb = 1'b1; c.Rout = 1'b1; c.PC_enable = 1'b1; end
          default: ;
        endcase
      end
      OP_IN:   if (step == 4'd4) begin c.InPortout = 1'b1; c.Gra = 1'b1; c.R_enable = 1'b1; end
      OP_OUT:  if (step == 4'd4) begin c.Gra = 1'b1; c.Rout = 1'b1; c.OutPort_enable = 1'b1; end
      OP_MFHI: if (step == 4'd4) begin c.HIout = 1'b1; c.Gra = 1'b1; c.R_enable = 1'b1; end
      OP_MFLO: if (step == 4'd4) begin c.LOout = 1'b1; c.Gra = 1'b1; c.R_enable = 1'b1; end
      default: ;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/control_unit.sv
// Hardwired Mini-SRC sequencer: fetch T0..T3, opcode-driven execute from T4,
// then back to fetch or into halt. Outputs decode from the current step only.
module control_unit
  import control_unit_pkg::*;
#(
  parameter int unsigned RESET_PC_HOLD = 1
) (
  input  logic       clk,
  input  logic       clr,
  input  logic [4:0] opcode,
  input  logic       con_ff,
  input  logic       stop,
  output logic       run,
  output logic       Gra, Grb, Grc, R_enable, Rout, BAout, Cout,
  output logic       PCout, MDRout, ZLowout, ZHighout, HIout, LOout, InPortout, Yout,
  output logic       PC_enable, IR_enable, MAR_enable, MDR_enable, Y_enable,
  output logic       Z_enable, HI_enable, LO_enable, CON_enable, OutPort_enable,
  output logic       IncPC, RAM_read, RAM_write,
  output logic [2:0] MDR_read
);

  localparam int unsigned HoldW = (RESET_PC_HOLD > 1) ? $clog2(RESET_PC_HOLD + 1) : 1;

  state_e           state_q, state_d;
  logic [3:0]       step_q, step_d;
  logic [HoldW-1:0] hold_q, hold_d;
  logic             last;
  ctrl_t            ctrl;

  assign last = (step_q == last_step(opcode));

  // Next state: reset hold countdown, step advance, retire to fetch or halt.
  always_comb begin
    state_d = state_q;
    step_d  = step_q;
    hold_d  = hold_q;
    case (state_q)
      S_RESET: begin
        if (32'(hold_q) + 32'd1 >= RESET_PC_HOLD) begin
          state_d = S_RUN;
          step_d  = '0;
        end else begin
          hold_d = hold_q + 1'b1;
        end
      end
      S_RUN: begin
        if (last) begin
          step_d  = '0;
          state_d = (stop || opcode == OP_HALT) ? S_HALT : S_RUN;
        end else begin
          step_d = step_q + 4'd1;
        end
      end
      S_HALT:  ;
      default: state_d = S_RESET;
    endcase
  end

  // State register with synchronous active-low clear.
  always_ff @(posedge clk) begin
    if (!clr) begin
      state_q <= S_RESET;
      step_q  <= '0;
      hold_q  <= '0;
    end else begin
      state_q <= state_d;
      step_q  <= step_d;
      hold_q  <= hold_d;
    end
  end

  // Strobe decode: fetch steps are fixed, execute steps come from the opcode table.
  always_comb begin
    ctrl = '0;
    if (state_q == S_RUN) begin
      case (step_q)
        4'd0: begin ctrl.PCout = 1'b1; ctrl.MAR_enable = 1'b1; ctrl.IncPC = 1'b1; ctrl.Z_enable = 1'b1; end
        4'd1: begin ctrl.ZLowout = 1'b1; ctrl.PC_enable = 1'b1; ctrl.RAM_read = 1'b1; end
        4'd2: begin ctrl.MDR_enable = 1'b1; ctrl.MDR_read = MDR_SEL_RAM; end
        4'd3: begin ctrl.MDRout = 1'b1; ctrl.IR_enable = 1'b1; end
        default: ctrl = exec_ctrl(opcode, step_q, con_ff);
      endcase
    end
  end

  assign run            = (state_q == S_RUN);
  assign Gra            = ctrl.Gra;
  assign Grb            = ctrl.Grb;
  assign Grc            = ctrl.Grc;
  assign R_enable       = ctrl.R_enable;
  assign Rout           = ctrl.Rout;
  assign BAout          = ctrl.BAout;
  assign Cout           = ctrl.Cout;
  assign PCout          = ctrl.PCout;
  assign MDRout         = ctrl.MDRout;
  assign ZLowout        = ctrl.ZLowout;
  assign ZHighout       = ctrl.ZHighout;
  assign HIout          = ctrl.HIout;
  assign LOout          = ctrl.LOout;
  assign InPortout      = ctrl.InPortout;
  assign Yout           = ctrl.Yout;
  assign PC_enable      = ctrl.PC_enable;
  assign IR_enable      = ctrl.IR_enable;
  assign MAR_enable     = ctrl.MAR_enable;
  assign MDR_enable     = ctrl.MDR_enable;
  assign Y_enable       = ctrl.Y_enable;
  assign Z_enable       = ctrl.Z_enable;
  assign HI_enable      = ctrl.HI_enable;
  assign LO_enable      = ctrl.LO_enable;
  assign CON_enable     = ctrl.CON_enable;
  assign OutPort_enable = ctrl.OutPort_enable;
  assign IncPC          = ctrl.IncPC;
  assign RAM_read       = ctrl.RAM_read;
  assign RAM_write      = ctrl.RAM_write;
  assign MDR_read       = ctrl.MDR_read;

endmodule

// File: tb/tb_control_unit.sv
// Self-checking bench for control_unit: per-instruction expected strobe
// sequences built from the instruction tables, compared cycle by cycle.
module tb_control_unit;
  import control_unit_pkg::*;

  localparam int unsigned HOLD = 1;

  localparam logic [31:0] GRA = 32'd1 << 0,  GRB = 32'd1 << 1,  GRC = 32'd1 << 2,  R_EN = 32'd1 << 3;
  localparam logic [31:0] ROUT = 32'd1 << 4, BAOUT = 32'd1 << 5, COUT = 32'd1 << 6, PCOUT = 32'd1 << 7;
  localparam logic [31:0] MDROUT = 32'd1 << 8, ZLOW = 32'd1 << 9, ZHIGH = 32'd1 << 10, HIOUT = 32'd1 << 11;
  localparam logic [31:0] LOOUT = 32'd1 << 12, INPORT = 32'd1 << 13, PC_EN = 32'd1 << 15, IR_EN = 32'd1 << 16;
  localparam logic [31:0] MAR_EN = 32'd1 << 17, MDR_EN = 32'd1 << 18, Y_EN = 32'd1 << 19, Z_EN = 32'd1 << 20;
  localparam logic [31:0] HI_EN = 32'd1 << 21, LO_EN = 32'd1 << 22, CON_EN = 32'd1 << 23, OUT_EN = 32'd1 << 24;
  localparam logic [31:0] INCPC = 32'd1 << 25, RAM_RD = 32'd1 << 26, RAM_WR = 32'd1 << 27, RUN = 32'd1 << 28;
  localparam logic [31:0] MDR_BUS = 32'd1 << 29, MDR_RAM = 32'd1 << 30;

  logic clk = 1'b0, clr = 1'b0, con_ff = 1'b0, stop = 1'b0;
  logic [4:0] opcode = 5'd0;
  logic run, Gra, Grb, Grc, R_enable, Rout, BAout, Cout;
  logic PCout, MDRout, ZLowout, ZHighout, HIout, LOout, InPortout, Yout;
  logic PC_enable, IR_enable, MAR_enable, MDR_enable, Y_enable;
  logic Z_enable, HI_enable, LO_enable, CON_enable, OutPort_enable;
  logic IncPC, RAM_read, RAM_write;
  logic [2:0] MDR_read;
  logic [31:0] obs;
  logic [31:0] exp_q[$];
  int n_tests = 0, n_fail = 0;

  control_unit #(.RESET_PC_HOLD(HOLD)) dut (
    .clk(clk), .clr(clr), .opcode(opcode), .con_ff(con_ff), .stop(stop), .run(run),
    .Gra(Gra), .Grb(Grb), .Grc(Grc), .R_enable(R_enable), .Rout(Rout), .BAout(BAout), .Cout(Cout),
    .PCout(PCout), .MDRout(MDRout), .ZLowout(ZLowout), .ZHighout(ZHighout), .HIout(HIout),
    .LOout(LOout), .InPortout(InPortout), .Yout(Yout),
    .PC_enable(PC_enable), .IR_enable(IR_enable), .MAR_enable(MAR_enable), .MDR_enable(MDR_enable),
    .Y_enable(Y_enable), .Z_enable(Z_enable), .HI_enable(HI_enable), .LO_enable(LO_enable),
    .CON_enable(CON_enable), .OutPort_enable(OutPort_enable),
    .IncPC(IncPC), .RAM_read(RAM_read), .RAM_write(RAM_write), .MDR_read(MDR_read)
  );

  always #5 clk = ~clk;

  assign obs = {MDR_read, run, RAM_write, RAM_read, IncPC, OutPort_enable, CON_enable, LO_enable,
                HI_enable, Z_enable, Y_enable, MDR_enable, MAR_enable, IR_enable, PC_enable,
                Yout, InPortout, LOout, HIout, ZHighout, ZLowout, MDRout, PCout,
                Cout, BAout, Rout, R_enable, Grc, Grb, Gra};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // One cycle: compare the whole strobe vector, then the bus/memory exclusivity rules.
  task automatic sample(input string tag, input logic [31:0] exp);
    logic [31:0] o;
    logic        bad;
    @(negedge clk);
    o   = obs;
    bad = ($countones(o[14:7]) > 1) || (o[26] && o[27]);
    check(tag, o, exp);
    check({tag, "_inv"}, {31'd0, bad}, 32'd0);
  endtask

  task automatic push(input logic [31:0] m);
    exp_q.push_back(m | RUN);
  endtask

  // Reference: fetch T0..T3 followed by the execute list of the instruction tables.
  task automatic build(input logic [4:0] op, input logic con);
    exp_q.delete();
    push(PCOUT | MAR_EN | INCPC | Z_EN);
    push(ZLOW | PC_EN | RAM_RD);
    push(MDR_EN | MDR_RAM);
    push(MDROUT | IR_EN);
    case (op)
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SHR, OP_SHRA, OP_SHL, OP_ROR, OP_ROL: begin
        push(GRB | ROUT | Y_EN); push(GRC | ROUT | Z_EN); push(ZLOW | GRA | R_EN);
      end
      OP_ADDI, OP_ANDI, OP_ORI: begin
        push(GRB | ROUT | Y_EN); push(COUT | Z_EN); push(ZLOW | GRA | R_EN);
      end
      OP_NEG, OP_NOT: begin push(GRB | ROUT | Z_EN); push(ZLOW | GRA | R_EN); end
      OP_MUL, OP_DIV: begin
        push(GRA | ROUT | Y_EN); push(GRB | ROUT | Z_EN); push(ZLOW | LO_EN); push(ZHIGH | HI_EN);
      end
      OP_LD: begin
        push(GRB | BAOUT | ROUT | Y_EN); push(COUT | Z_EN); push(ZLOW | MAR_EN);
        push(RAM_RD); push(MDR_EN | MDR_RAM); push(MDROUT | GRA | R_EN);
      end
      OP_LDI: begin push(GRB | BAOUT | ROUT | Y_EN); push(COUT | Z_EN); push(ZLOW | GRA | R_EN); end
      OP_ST: begin
        push(GRB | BAOUT | ROUT | Y_EN); push(COUT | Z_EN); push(ZLOW | MAR_EN);
        push(GRA | ROUT | MDR_EN | MDR_BUS); push(RAM_WR);
      end
      OP_BR: begin
        push(GRA | ROUT | CON_EN); push(PCOUT | Y_EN); push(COUT | Z_EN);
        push(con ? (ZLOW | PC_EN) : 32'd0);
      end
      OP_JR:   push(GRA | ROUT | PC_EN);
      OP_JAL:  begin push(PCOUT | GRA | R_EN); push(GRB | ROUT | PC_EN); end
      OP_IN:   push(INPORT | GRA | R_EN);
      OP_OUT:  push(GRA | ROUT | OUT_EN);
      OP_MFHI: push(HIOUT | GRA | R_EN);
      OP_MFLO: push(LOOUT | GRA | R_EN);
      default: ;
    endcase
  endtask

  // clr low for two edges, then the hold period; the next sampled cycle is T0.
  task automatic do_reset();
    clr = 1'b0;
    sample("rst0", 32'd0);
    sample("rst1", 32'd0);
    clr = 1'b1;
    for (int i = 1; i < int'(HOLD); i++) sample("hold", 32'd0);
  endtask

  task automatic run_instr(input logic [4:0] op, input logic con, input logic stp, input int abort_at);
    int n;
    build(op, con);
    n = exp_q.size();
    for (int k = 0; k < n; k++) begin
      sample($sformatf("op%0d_T%0d", op, k), exp_q[k]);
      if (k == 0) begin opcode = op; con_ff = con; end
      if (k == abort_at) begin do_reset(); return; end
      stop = (k == n - 1) ? stp : 1'($urandom_range(0, 1));
    end
    if (stp || op == OP_HALT) begin
      for (int i = 0; i < 20; i++) begin
        sample($sformatf("halt%0d", i), 32'd0);
        opcode = 5'($urandom_range(0, 31));
        stop   = 1'($urandom_range(0, 1));
      end
      do_reset();
    end
  endtask

  initial begin
    do_reset();
    run_instr(OP_ADD, 1'b0, 1'b0, -1);
    run_instr(OP_BR,  1'b0, 1'b0, -1);
    run_instr(OP_BR,  1'b1, 1'b0, -1);
    run_instr(OP_ST,  1'b0, 1'b0, -1);
    run_instr(OP_LD,  1'b0, 1'b0, -1);
    run_instr(OP_MUL, 1'b0, 1'b0, 5);
    run_instr(OP_JAL, 1'b0, 1'b0, -1);
    run_instr(OP_ADD, 1'b0, 1'b1, -1);
    run_instr(OP_HALT, 1'b0, 1'b0, -1);
    run_instr(5'b11110, 1'b0, 1'b0, -1);
    for (int i = 0; i < 120; i++) begin
      logic [4:0] op;
      logic       c, s;
      int         ab;
      op = 5'($urandom_range(0, 31));
      c  = 1'($urandom_range(0, 1));
      s  = ($urandom_range(0, 11) == 0);
      ab = ($urandom_range(0, 19) == 0) ? int'($urandom_range(0, 9)) : -1;
      run_instr(op, c, s, ab);
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
